// File: rtl/ema_pkg.sv
// rtl/ema_pkg.sv - ALU mode constants and FSM state encoding for the EMA channel scheduler.
package ema_pkg;

    localparam logic [1:0] ALU_IDLE = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_MULT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XMUL,
        S_XWAIT,
        S_YMUL,
        S_YWAIT,
        S_SUM
    } state_t;

endpackage

// File: rtl/ema_channel_scheduler_rr_arbiter.sv
// rtl/ema_channel_scheduler_rr_arbiter.sv - round-robin arbiter: search from ptr, one-hot grant plus winner index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = '0;
        for (int k = 0; k < N; k++) begin
            c = IW'((int'(ptr) + k) % N);
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

endmodule

// File: rtl/ema_channel_scheduler.sv
// rtl/ema_channel_scheduler.sv - shares one multiply ALU across NCH EMA channels, round-robin.
// Optional ALU response timeout enabled by defining EMA_SCHED_TIMEOUT_EN.
module ema_channel_scheduler
    import ema_pkg::*;
#(
    parameter int NCH = 4,
    parameter int Win = 16,
    parameter int CHW = 2,
    parameter int TMO = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req_valid_i,
    output logic [NCH-1:0]     req_ready_o,
    input  logic [NCH*Win-1:0] x_i,
    input  logic [NCH*Win-1:0] alpha_i,
    output logic [1:0]         alu_mode_o,
    output logic [Win-1:0]     alu_op1_o,
    output logic [Win:0]       alu_op2_o,
    output logic               alu_valid_o,
    input  logic [2*Win-1:0]   alu_res_i,
    input  logic               alu_valid_i,
    output logic [Win-1:0]     y_o,
    output logic [CHW-1:0]     ch_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               err_o
);

    state_t         state;
    logic [Win-1:0] y_last [NCH];
    logic [Win-1:0] a_r, px, res_hi, y_sum, x_sel, a_sel;
    logic [CHW-1:0] ch_r, ptr, win_idx;
    logic [NCH-1:0] grant;
    logic           any, tmo_hit, unused_bits;

    rr_arbiter #(.N(NCH), .IW(CHW)) u_arb (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any)
    );

    assign req_ready_o = (state == S_IDLE && !rst) ? grant : '0;
    assign busy_o      = (state != S_IDLE);
    assign x_sel       = x_i[win_idx*Win +: Win];
    assign a_sel       = alpha_i[win_idx*Win +: Win];
    // Q0.Win scaling: arithmetic >>> Win then truncation is just the upper half.
    assign res_hi      = alu_res_i[2*Win-1:Win];
    assign y_sum       = px + res_hi;
    assign unused_bits = ^{alu_res_i[Win-1:0], TMO[0]};

`ifdef EMA_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO) + 1;
    logic [CW-1:0] cnt;
    logic          waiting;

    assign waiting = (state == S_XWAIT) || (state == S_YWAIT);
    assign tmo_hit = waiting && (cnt == CW'(TMO - 1));

    // err_o is raised one edge early so it lines up with the last wait cycle.
    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            err_o <= (cnt == CW'(TMO - 2)) && !alu_valid_i;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            a_r         <= '0;
            ch_r        <= '0;
            px          <= '0;
            alu_mode_o  <= ALU_IDLE;
            alu_op1_o   <= '0;
            alu_op2_o   <= '0;
            alu_valid_o <= 1'b0;
            y_o         <= '0;
            ch_o        <= '0;
            valid_o     <= 1'b0;
            for (int c = 0; c < NCH; c++) y_last[c] <= '0;
        end else begin
            alu_valid_o <= 1'b0;
            alu_mode_o  <= ALU_IDLE;
            valid_o     <= 1'b0;
            case (state)
                S_IDLE: if (any) begin
                    a_r         <= a_sel;
                    ch_r        <= win_idx;
                    ptr         <= (win_idx == CHW'(NCH - 1)) ? '0 : win_idx + 1'b1;
                    alu_op1_o   <= x_sel;
                    alu_op2_o   <= {1'b0, a_sel};
                    alu_mode_o  <= ALU_MULT;
                    alu_valid_o <= 1'b1;
                    state       <= S_XMUL;
                end
                S_XMUL: state <= S_XWAIT;
                S_XWAIT: begin
                    if (tmo_hit) begin
                        state <= S_IDLE;
                    end else if (alu_valid_i) begin
                        px          <= res_hi;
                        alu_op1_o   <= y_last[ch_r];
                        alu_op2_o   <= {1'b0, ~a_r};
                        alu_mode_o  <= ALU_MULT;
                        alu_valid_o <= 1'b1;
                        state       <= S_YMUL;
                    end
                end
                S_YMUL: state <= S_YWAIT;
                S_YWAIT: begin
                    if (tmo_hit) begin
                        state <= S_IDLE;
                    end else if (alu_valid_i) begin
                        y_o          <= y_sum;
                        ch_o         <= ch_r;
                        valid_o      <= 1'b1;
                        y_last[ch_r] <= y_sum;
                        state        <= S_SUM;
                    end
                end
                S_SUM:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
